// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and helpers for the EX-stage branch resolve unit and its 2-bit BHT.
package branch_resolve_unit_pkg;

  localparam int unsigned XLEN_DEF        = 32;
  localparam int unsigned BHT_ENTRIES_DEF = 64;
  localparam int unsigned CNT_W           = 32;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_state_e;

  localparam bht_state_e BHT_RESET = BHT_WNT;

  typedef enum logic [1:0] {
    CF_NONE,
    CF_BRANCH,
    CF_JAL,
    CF_JALR
  } cf_kind_e;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic bht_state_e bht_next(input bht_state_e s, input logic taken);
    if (taken) return (s == BHT_ST)  ? BHT_ST  : bht_state_e'(s + 2'd1);
    else       return (s == BHT_SNT) ? BHT_SNT : bht_state_e'(s - 2'd1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// 2-bit saturating branch history table: one combinational read port for fetch,
// one synchronous saturating-update write port for EX.
module branch_resolve_unit_bht
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned ENTRIES = BHT_ENTRIES_DEF,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken_c,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_state_e bht_q [ENTRIES];

  // Read sees the pre-update value when it collides with a same-cycle write.
  assign rd_taken_c = bht_q[rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) bht_q[i] <= BHT_RESET;
    end else if (wr_en) begin
      bht_q[wr_idx] <= bht_next(bht_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: target computation, misprediction detection,
// registered redirect/flush and misalignment pulses, counters and BHT training.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned BHT_ENTRIES = BHT_ENTRIES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic              ex_is_branch,
  input  logic              ex_is_jal,
  input  logic              ex_is_jalr,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic              ex_pred_taken,
  input  logic              branch_out,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush,
  output logic              misalign_exc,
  output logic [XLEN-1:0]   misalign_addr,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  cf_kind_e          kind_c;
  logic              resolve_c;
  logic              taken_c;
  logic              mispred_c;
  logic              do_redirect_c;
  logic              do_misalign_c;
  logic [XLEN-1:0]   tgt_c;
  logic              if_pc_unused;

  // Overlapping type flags are a decode error; jalr wins, then jal, then branch.
  always_comb begin
    kind_c = CF_NONE;
    if (ex_is_jalr)        kind_c = CF_JALR;
    else if (ex_is_jal)    kind_c = CF_JAL;
    else if (ex_is_branch) kind_c = CF_BRANCH;
  end

  always_comb begin
    taken_c   = 1'b0;
    mispred_c = 1'b0;
    tgt_c     = ex_pc + ex_imm;
    case (kind_c)
      CF_BRANCH: begin
        taken_c   = branch_out;
        mispred_c = (branch_out != ex_pred_taken);
      end
      CF_JAL: begin
        taken_c   = 1'b1;
        mispred_c = ~ex_pred_taken;
      end
      CF_JALR: begin
        taken_c   = 1'b1;
        mispred_c = 1'b1;
        tgt_c     = (ex_rs1 + ex_imm) & {{(XLEN-1){1'b1}}, 1'b0};
      end
      default: ;
    endcase
  end

  // The wrong-path instruction behind a redirect is squashed via ~redirect_valid.
  assign resolve_c     = ex_valid & ~ex_stall & ~redirect_valid & (kind_c != CF_NONE);
  assign do_misalign_c = resolve_c & taken_c & (tgt_c[1:0] != 2'b00);
  assign do_redirect_c = resolve_c & mispred_c & ~do_misalign_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      misalign_exc   <= 1'b0;
      misalign_addr  <= '0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
    end else begin
      redirect_valid <= do_redirect_c;
      misalign_exc   <= do_misalign_c;
      if (do_redirect_c) begin
        redirect_pc <= taken_c ? tgt_c : ex_pc + XLEN'(4);
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
      if (do_misalign_c) misalign_addr <= tgt_c;
      if (resolve_c && kind_c == CF_BRANCH) branch_cnt <= branch_cnt + CNT_W'(1);
    end
  end

  assign flush        = redirect_valid;
  assign if_pc_unused = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  branch_resolve_unit_bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (if_pc[IDX_W+1:2]),
    .rd_taken_c (if_pred_taken),
    .wr_en      (resolve_c && kind_c == CF_BRANCH),
    .wr_idx     (ex_pc[IDX_W+1:2]),
    .wr_taken   (taken_c)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the resolve rules and BHT.
module tb_branch_resolve_unit;

  logic        clk, rst_n;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [31:0] ex_pc, ex_imm, ex_rs1, if_pc;
  logic        ex_pred_taken, branch_out;
  logic        if_pred_taken, redirect_valid, flush, misalign_exc;
  logic [31:0] redirect_pc, misalign_addr, branch_cnt, mispred_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int          m_bht [64];
  bit          m_rv, m_me;
  logic [31:0] m_rpc, m_maddr, m_bc, m_mc;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_pred_taken(ex_pred_taken),
    .branch_out(branch_out), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_rv = 0; m_me = 0; m_rpc = '0; m_maddr = '0; m_bc = '0; m_mc = '0;
  endfunction

  task automatic set_op(input bit v, input bit st, input bit br, input bit jal, input bit jalr,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input bit pred, input bit bout);
    ex_valid = v; ex_stall = st; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; ex_pred_taken = pred; branch_out = bout;
  endtask

  task automatic idle();
    set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
  endtask

  // Advance one clock, evolving the model from the inputs presented before the edge.
  task automatic tick();
    int k, idx;
    bit tk, mp, n_rv, n_me, upd;
    logic [31:0] tgt, n_rpc, n_maddr, n_bc, n_mc;
    k   = ex_is_jalr ? 3 : (ex_is_jal ? 2 : (ex_is_branch ? 1 : 0));
    tk  = (k == 1) ? branch_out : 1'b1;
    tgt = (k == 3) ? ((ex_rs1 + ex_imm) / 2) * 2 : ex_pc + ex_imm;
    mp  = (k == 3) || (k == 2 && !ex_pred_taken) || (k == 1 && branch_out != ex_pred_taken);
    n_rv = 0; n_me = 0; n_rpc = m_rpc; n_maddr = m_maddr; n_bc = m_bc; n_mc = m_mc; upd = 0;
    idx = int'((ex_pc / 4) % 64);
    if (ex_valid && !ex_stall && !m_rv && k != 0) begin
      if (tk && (tgt % 4) != 0) begin
        n_me = 1; n_maddr = tgt;
      end else if (mp) begin
        n_rv = 1; n_rpc = tk ? tgt : ex_pc + 4; n_mc = n_mc + 1;
      end
      if (k == 1) begin
        n_bc = n_bc + 1; upd = 1;
      end
    end
    @(posedge clk); #1;
    m_rv = n_rv; m_me = n_me; m_rpc = n_rpc; m_maddr = n_maddr; m_bc = n_bc; m_mc = n_mc;
    if (upd) m_bht[idx] = tk ? ((m_bht[idx] == 3) ? 3 : m_bht[idx] + 1)
                             : ((m_bht[idx] == 0) ? 0 : m_bht[idx] - 1);
  endtask

  task automatic test_reset();
    idle(); if_pc = '0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || misalign_exc !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: rv=%b fl=%b me=%b want 0", redirect_valid, flush, misalign_exc); end
    checks++; if (redirect_pc !== 32'h0 || misalign_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addrs: rpc=%h maddr=%h want 0", redirect_pc, misalign_addr); end
    checks++; if (branch_cnt !== 32'h0 || mispred_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_cnts: bc=%0d mc=%0d want 0", branch_cnt, mispred_cnt); end
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i) * 32'd4; #1;
      checks++; if (if_pred_taken !== 1'b0) begin
        errors++; $display("FAIL reset_bht idx=%0d: got %b want 0", i, if_pred_taken); end
    end
  endtask

  task automatic test_beq_mispredict();
    set_op(1, 0, 1, 0, 0, 32'h100, 32'h20, 32'h0, 0, 1);
    tick();
    checks++; if (redirect_valid !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h120) begin
      errors++; $display("FAIL beq_redirect: rv=%b fl=%b rpc=%h want 1 1 120", redirect_valid, flush, redirect_pc); end
    checks++; if (mispred_cnt !== 32'd1 || branch_cnt !== 32'd1) begin
      errors++; $display("FAIL beq_cnts: mc=%0d bc=%0d want 1 1", mispred_cnt, branch_cnt); end
    idle(); tick();
    if_pc = 32'h100; #1;
    checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || if_pred_taken !== 1'b1) begin
      errors++; $display("FAIL beq_after: rv=%b fl=%b pred=%b want 0 0 1", redirect_valid, flush, if_pred_taken); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) begin
      set_op(1, 0, 1, 0, 0, 32'h100, 32'h20, 32'h0, 1, 1);
      tick();
      checks++; if (redirect_valid !== 1'b0) begin
        errors++; $display("FAIL sat_noredir%0d: rv=%b want 0", i, redirect_valid); end
    end
    checks++; if (branch_cnt !== 32'd4 || mispred_cnt !== 32'd1 || if_pred_taken !== 1'b1) begin
      errors++; $display("FAIL sat_state: bc=%0d mc=%0d pred=%b want 4 1 1", branch_cnt, mispred_cnt, if_pred_taken); end
    for (int i = 0; i < 2; i++) begin
      set_op(1, 0, 1, 0, 0, 32'h100, 32'h20, 32'h0, 1, 0);
      tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin
        errors++; $display("FAIL sat_nt%0d: rv=%b rpc=%h want 1 104", i, redirect_valid, redirect_pc); end
      idle(); tick(); #1;
      checks++; if (if_pred_taken !== (i == 0) || branch_cnt !== 32'(5 + i) || mispred_cnt !== 32'(2 + i)) begin
        errors++; $display("FAIL sat_dec%0d: pred=%b bc=%0d mc=%0d want %0d %0d %0d", i, if_pred_taken,
                           branch_cnt, mispred_cnt, i == 0, 5 + i, 2 + i); end
    end
  endtask

  task automatic test_jumps();
    set_op(1, 0, 0, 0, 1, 32'h400, 32'h1, 32'h2003, 0, 0); tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2004 || mispred_cnt !== 32'd4) begin
      errors++; $display("FAIL jalr1: rv=%b rpc=%h mc=%0d want 1 2004 4", redirect_valid, redirect_pc, mispred_cnt); end
    idle(); tick();
    set_op(1, 0, 0, 0, 1, 32'h400, 32'h0, 32'h2001, 1, 0); tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2000 || mispred_cnt !== 32'd5) begin
      errors++; $display("FAIL jalr2: rv=%b rpc=%h mc=%0d want 1 2000 5", redirect_valid, redirect_pc, mispred_cnt); end
    idle(); tick();
    set_op(1, 0, 0, 1, 0, 32'h100, 32'h6, 32'h0, 0, 0); tick();
    checks++; if (misalign_exc !== 1'b1 || misalign_addr !== 32'h106 || redirect_valid !== 1'b0 || mispred_cnt !== 32'd5) begin
      errors++; $display("FAIL jal_misalign: me=%b maddr=%h rv=%b mc=%0d want 1 106 0 5", misalign_exc,
                         misalign_addr, redirect_valid, mispred_cnt); end
    idle(); tick();
    checks++; if (misalign_exc !== 1'b0) begin
      errors++; $display("FAIL jal_me_drop: me=%b want 0", misalign_exc); end
    set_op(1, 0, 0, 1, 0, 32'h100, 32'h8, 32'h0, 1, 0); tick();
    checks++; if (redirect_valid !== 1'b0 || misalign_exc !== 1'b0) begin
      errors++; $display("FAIL jal_pred_ok: rv=%b me=%b want 0 0", redirect_valid, misalign_exc); end
    set_op(1, 0, 1, 1, 1, 32'h100, 32'h10, 32'h3000, 1, 0); tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3010 || branch_cnt !== 32'd6 || mispred_cnt !== 32'd6) begin
      errors++; $display("FAIL multi_flag: rv=%b rpc=%h bc=%0d mc=%0d want 1 3010 6 6", redirect_valid,
                         redirect_pc, branch_cnt, mispred_cnt); end
    idle(); tick();
  endtask

  task automatic test_back_to_back();
    set_op(1, 0, 1, 0, 0, 32'h204, 32'h40, 32'h0, 0, 1); tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h244) begin
      errors++; $display("FAIL b2b_first: rv=%b rpc=%h want 1 244", redirect_valid, redirect_pc); end
    set_op(1, 0, 1, 0, 0, 32'h308, 32'h10, 32'h0, 0, 1); tick();
    if_pc = 32'h308; #1;
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h244 || if_pred_taken !== 1'b0) begin
      errors++; $display("FAIL b2b_squash: rv=%b rpc=%h pred=%b want 0 244 0", redirect_valid, redirect_pc, if_pred_taken); end
    checks++; if (branch_cnt !== 32'd7 || mispred_cnt !== 32'd7) begin
      errors++; $display("FAIL b2b_cnts: bc=%0d mc=%0d want 7 7", branch_cnt, mispred_cnt); end
    idle(); tick();
    for (int i = 0; i < 3; i++) begin
      set_op(1, 1, 1, 0, 0, 32'h18c, 32'h8, 32'h0, 1, 0); tick();
      checks++; if (redirect_valid !== 1'b0 || branch_cnt !== 32'd7) begin
        errors++; $display("FAIL stall%0d: rv=%b bc=%0d want 0 7", i, redirect_valid, branch_cnt); end
    end
    ex_stall = 1'b0; tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h190 || branch_cnt !== 32'd8 || mispred_cnt !== 32'd8) begin
      errors++; $display("FAIL stall_release: rv=%b rpc=%h bc=%0d mc=%0d want 1 190 8 8", redirect_valid,
                         redirect_pc, branch_cnt, mispred_cnt); end
    idle(); tick();
  endtask

  task automatic test_reset_mid();
    set_op(1, 0, 1, 0, 0, 32'h100, 32'h20, 32'h0, 0, 1); tick();
    if_pc = 32'h100; #1;
    checks++; if (redirect_valid !== 1'b1 || if_pred_taken !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: rv=%b pred=%b want 1 1", redirect_valid, if_pred_taken); end
    idle(); rst_n = 1'b0; #1;
    checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h0) begin
      errors++; $display("FAIL rstmid_redir: rv=%b fl=%b rpc=%h want 0 0 0", redirect_valid, flush, redirect_pc); end
    checks++; if (branch_cnt !== 32'h0 || mispred_cnt !== 32'h0 || if_pred_taken !== 1'b0) begin
      errors++; $display("FAIL rstmid_state: bc=%0d mc=%0d pred=%b want 0 0 0", branch_cnt, mispred_cnt, if_pred_taken); end
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    int r;
    bit exp_pred;
    for (int c = 0; c < 400; c++) begin
      r = int'($urandom_range(0, 9));
      ex_valid      = ($urandom_range(0, 9) != 0);
      ex_stall      = ($urandom_range(0, 5) == 0);
      ex_is_branch  = (r < 6) || (r == 9);
      ex_is_jal     = (r == 6) || (r == 9);
      ex_is_jalr    = (r == 7);
      ex_pc         = 32'($urandom_range(0, 255)) * 32'd4;
      ex_imm        = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 15)) : ($urandom() & 32'hFFFF_FFFC);
      ex_rs1        = $urandom();
      ex_pred_taken = 1'($urandom_range(0, 1));
      branch_out    = 1'($urandom_range(0, 1));
      if_pc         = ($urandom_range(0, 1) == 0) ? ex_pc : $urandom();
      #1;
      exp_pred = (m_bht[int'((if_pc / 4) % 64)] >= 2);
      checks++; if (if_pred_taken !== exp_pred) begin
        errors++; $display("FAIL rnd_pred c=%0d: got %b want %b", c, if_pred_taken, exp_pred); end
      tick();
      checks++; if (redirect_valid !== m_rv || flush !== m_rv || redirect_pc !== m_rpc) begin
        errors++; $display("FAIL rnd_redir c=%0d: rv=%b fl=%b rpc=%h want %b %b %h", c, redirect_valid, flush,
                           redirect_pc, m_rv, m_rv, m_rpc); end
      checks++; if (misalign_exc !== m_me || misalign_addr !== m_maddr) begin
        errors++; $display("FAIL rnd_misalign c=%0d: me=%b maddr=%h want %b %h", c, misalign_exc,
                           misalign_addr, m_me, m_maddr); end
      checks++; if (branch_cnt !== m_bc || mispred_cnt !== m_mc) begin
        errors++; $display("FAIL rnd_cnts c=%0d: bc=%0d mc=%0d want %0d %0d", c, branch_cnt, mispred_cnt, m_bc, m_mc); end
    end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_saturate();
    test_jumps();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
